y86_stage_ctrl: RTL and testbench
=================================

# y86_stage_ctrl

Multi-cycle sequencer for the Y86-64 core. It steps one instruction at a time through fetch, decode, execute, memory, write-back and PC-update, issuing one-cycle stage enables to the shared datapath. It drives `set_cc_o` to the execute stage's condition-code register and runs the data-memory request/ready handshake. It also maintains the architectural status code and stops the machine on halt or error.

## Interface
Parameters:
- `ICODE_W`, 4: instruction code width.
- `STAT_W`, 3: status code width.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  begin execution; sampled only in IDLE.
- `icode_i`  in  4  instruction code from fetch; valid in DECODE and later states.
- `ifunc_i`  in  4  function code from fetch.
- `imem_error_i`  in  1  instruction address fault; sampled in FETCH.
- `dmem_ready_i`  in  1  data memory completes the current request.
- `dmem_error_i`  in  1  data address fault; qualified by `dmem_ready_i`.
- `f_en_o`, `d_en_o`, `e_en_o`, `w_en_o`, `pc_en_o`  out  1 each  stage enables, one cycle each.
- `set_cc_o`  out  1  condition-code load; equals `e_en_o` AND icode==OPQ.
- `dmem_req_o`  out  1  data memory request.
- `dmem_wr_o`  out  1  write qualifier for `dmem_req_o`.
- `retire_o`  out  1  pulses in the PC state.
- `busy_o`  out  1  high in any state except IDLE and HALT.
- `stat_o`  out  3  status code: AOK=1, HLT=2, ADR=3, INS=4.
- `cycle_cnt_o`  out  64  busy-cycle counter (see Configuration).
- `instr_cnt_o`  out  64  retired-instruction counter (see Configuration).

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PC, HALT. Each state's enable output is high exactly while in that state.

Transitions:
- IDLE → FETCH when `start_i` is high.
- FETCH → HALT with stat ADR if `imem_error_i` is high; otherwise → DECODE.
- DECODE → HALT with stat INS on an invalid instruction:
  - icode > 0xB;
  - OPQ with ifunc > 3;
  - CMOVQ or JXX with ifunc > 6.
- DECODE → HALT with stat HLT on icode==HALT.
- DECODE → EXEC in all other cases.
- EXEC → MEM for RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ; otherwise → WB.
- MEM holds until `dmem_ready_i` is high:
  - if `dmem_error_i` is also high → HALT with stat ADR;
  - otherwise → WB.
- WB → PC.
- PC → FETCH. Execution continues without `start_i`.
- HALT is absorbing. Only `rst_i` leaves it, and `start_i` is ignored there.

Memory handshake:
- `dmem_req_o` is high for every cycle in MEM, including the completing cycle.
- `dmem_wr_o` is high in MEM for RMMOVQ, CALL and PUSHQ; low otherwise.
- `dmem_ready_i` and `dmem_error_i` are ignored outside MEM.

Status:
- `stat_o` is registered. It changes on the edge that enters HALT and holds afterwards.
- No stage enable, `set_cc_o` or `retire_o` fires in HALT.
- A HALT instruction does not retire.

Reset:
- Reset at any point, including mid-MEM, forces IDLE.
- All enables, `dmem_req_o`, `retire_o` and `busy_o` go to 0; `stat_o` goes to AOK; counters go to 0.
- Reset wins over every other input in the same cycle.

## Timing
- Registered state; all outputs are decoded from the registered state plus `icode_i`, with no other input-to-output paths.
- `start_i` high at edge N → FETCH during cycle N+1.
- Non-memory instruction: 5 cycles, FETCH through PC.
- Memory instruction: 6 + k cycles, where k is the number of MEM cycles with `dmem_ready_i` low.
- `retire_o` rate: one pulse every 5 cycles for back-to-back non-memory instructions.
- Fault latency: an error sampled at edge N puts the block in HALT from cycle N+1, with `stat_o` updated at the same edge.

## Configuration
Macro: `Y86_PERF_CNT_EN`.
- Defined:
  - `cycle_cnt_o` increments every cycle `busy_o` is high.
  - `instr_cnt_o` increments on every `retire_o`.
  - Both wrap modulo 2^64 and both hold in IDLE and HALT.
- Undefined: the counter logic is removed and both ports are tied to 0. The port list is unchanged.

## Structure
- Package `y86_pkg` holds:
  - icode constants: HALT 0, NOP 1, CMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B;
  - ALU function codes;
  - stat codes;
  - the state enum typedef.
- Sub-module `y86_perf_cnt` holds the two 64-bit counters. It is instantiated only under `Y86_PERF_CNT_EN`.

## Test plan
- Reset, then `start_i` with IRMOVQ (icode 3) → enables F, D, E, W, PC in consecutive cycles; `set_cc_o`=0; `retire_o` once; `stat_o`=1.
- OPQ with ifunc 1 → `set_cc_o` high only in the EXEC cycle; MEM skipped; 5-cycle latency.
- PUSHQ with `dmem_ready_i` held low 3 cycles → `dmem_req_o`=`dmem_wr_o`=1 for 4 cycles; total 9 cycles.
- MRMOVQ with `dmem_ready_i`=`dmem_error_i`=1 → HALT with `stat_o`=3; no retire; a later `start_i` is ignored.
- icode 0xC, then separately OPQ with ifunc 5 → `stat_o`=4; HALT instruction → `stat_o`=2 after DECODE.
- `rst_i` in the middle of MEM → IDLE, `stat_o`=1, all outputs 0. With `Y86_PERF_CNT_EN` defined, 3 NOPs → `instr_cnt_o`=3 and `cycle_cnt_o`=15.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icode, ALU function and stat constants, sequencer state enum, memory-class helpers
package y86_pkg;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_CMOVQ = 4'h2, I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_XOR = 4'h3;
  localparam logic [3:0] FN_MAX_OPQ = ALU_XOR, FN_MAX_COND = 4'h6;
  localparam logic [2:0] S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_PC, ST_HALT
  } state_e;
  function automatic logic is_mem(input logic [3:0] ic);
    return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction
  function automatic logic is_wr(input logic [3:0] ic);
    return ic inside {I_RMMOVQ, I_CALL, I_PUSHQ};
  endfunction
endpackage

// File: rtl/y86_perf_cnt.sv
// y86_perf_cnt: 64-bit busy-cycle and retired-instruction counters (clk_i, rst_i, busy_i, retire_i -> cycle_cnt_o, instr_cnt_o)
module y86_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        busy_i,
  input  logic        retire_i,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instr_cnt_o
);
  logic [63:0] cycle_q, cycle_d, instr_q, instr_d;
  always_comb begin
    cycle_d = busy_i ? cycle_q + 64'd1 : cycle_q;
    instr_d = retire_i ? instr_q + 64'd1 : instr_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end
  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;
endmodule

// File: rtl/y86_stage_ctrl.sv
// y86_stage_ctrl: Y86-64 multi-cycle sequencer; start/icode/ifunc/mem faults/dmem_ready in, stage enables, set_cc, dmem req/wr, retire, busy, stat, perf counters (Y86_PERF_CNT_EN) out
module y86_stage_ctrl
  import y86_pkg::*;
#(
  parameter int ICODE_W = 4,
  parameter int STAT_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [ICODE_W-1:0] icode_i,
  input  logic [3:0]         ifunc_i,
  input  logic               imem_error_i,
  input  logic               dmem_ready_i,
  input  logic               dmem_error_i,
  output logic               f_en_o,
  output logic               d_en_o,
  output logic               e_en_o,
  output logic               w_en_o,
  output logic               pc_en_o,
  output logic               set_cc_o,
  output logic               dmem_req_o,
  output logic               dmem_wr_o,
  output logic               retire_o,
  output logic               busy_o,
  output logic [STAT_W-1:0]  stat_o,
  output logic [63:0]        cycle_cnt_o,
  output logic [63:0]        instr_cnt_o
);
  state_e state_q, state_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic bad, hlt, mem_fault;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      stat_q  <= S_AOK;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
    end
  end
  always_comb begin
    bad = icode_i > I_POPQ || (icode_i == I_OPQ && ifunc_i > FN_MAX_OPQ)
       || ((icode_i == I_CMOVQ || icode_i == I_JXX) && ifunc_i > FN_MAX_COND);
    hlt = icode_i == I_HALT;
    mem_fault = dmem_ready_i && dmem_error_i;
    state_d = state_q;
    stat_d = stat_q;
    case (state_q)
      ST_IDLE:   state_d = start_i ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        state_d = imem_error_i ? ST_HALT : ST_DECODE;
        stat_d = imem_error_i ? S_ADR : stat_q;
      end
      ST_DECODE: begin
        state_d = (bad || hlt) ? ST_HALT : ST_EXEC;
        stat_d = bad ? S_INS : hlt ? S_HLT : stat_q;
      end
      ST_EXEC:   state_d = is_mem(icode_i) ? ST_MEM : ST_WB;
      ST_MEM: begin
        state_d = !dmem_ready_i ? ST_MEM : dmem_error_i ? ST_HALT : ST_WB;
        stat_d = mem_fault ? S_ADR : stat_q;
      end
      ST_WB:     state_d = ST_PC;
      ST_PC:     state_d = ST_FETCH;
      default:   state_d = ST_HALT;
    endcase
  end
  always_comb begin
    f_en_o = state_q == ST_FETCH;
    d_en_o = state_q == ST_DECODE;
    e_en_o = state_q == ST_EXEC;
    w_en_o = state_q == ST_WB;
    pc_en_o = state_q == ST_PC;
    set_cc_o = e_en_o && icode_i == I_OPQ;
    dmem_req_o = state_q == ST_MEM;
    dmem_wr_o = dmem_req_o && is_wr(icode_i);
    retire_o = pc_en_o;
    busy_o = !(state_q inside {ST_IDLE, ST_HALT});
  end
  assign stat_o = stat_q;
`ifdef Y86_PERF_CNT_EN
  y86_perf_cnt u_perf_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .busy_i      (busy_o),
    .retire_i    (retire_o),
    .cycle_cnt_o (cycle_cnt_o),
    .instr_cnt_o (instr_cnt_o)
  );
`else
  assign cycle_cnt_o = '0;
  assign instr_cnt_o = '0;
`endif
endmodule

// File: tb/tb_y86_stage_ctrl.sv
// tb_y86_stage_ctrl: directed self-checking bench for the Y86-64 stage sequencer
module tb_y86_stage_ctrl;
  logic clk = 0, rst = 1, start = 0, imem_err = 0, dready = 0, derr = 0;
  logic [3:0] icode = 0, ifunc = 0;
  logic f_en, d_en, e_en, w_en, pc_en, set_cc, req, wr, retire, busy;
  logic [2:0] stat;
  logic [63:0] cyc_cnt, ins_cnt;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  y86_stage_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .icode_i(icode), .ifunc_i(ifunc),
    .imem_error_i(imem_err), .dmem_ready_i(dready), .dmem_error_i(derr),
    .f_en_o(f_en), .d_en_o(d_en), .e_en_o(e_en), .w_en_o(w_en), .pc_en_o(pc_en),
    .set_cc_o(set_cc), .dmem_req_o(req), .dmem_wr_o(wr), .retire_o(retire),
    .busy_o(busy), .stat_o(stat), .cycle_cnt_o(cyc_cnt), .instr_cnt_o(ins_cnt)
  );
  wire [12:0] obs = {f_en, d_en, e_en, w_en, pc_en, set_cc, req, wr, retire, busy, stat};
  localparam logic [12:0] F  = 13'b1_0000_0000_1001, D  = 13'b0_1000_0000_1001;
  localparam logic [12:0] E  = 13'b0_0100_0000_1001, EC = 13'b0_0100_1000_1001;
  localparam logic [12:0] M  = 13'b0_0000_0100_1001, MW = 13'b0_0000_0110_1001;
  localparam logic [12:0] W  = 13'b0_0010_0000_1001, P  = 13'b0_0001_0001_1001;
  localparam logic [12:0] ID = 13'b0_0000_0000_0001, H2 = 13'b0_0000_0000_0010;
  localparam logic [12:0] H3 = 13'b0_0000_0000_0011, H4 = 13'b0_0000_0000_0100;
`ifdef Y86_PERF_CNT_EN
  localparam logic [63:0] X_CYC = 64'd15, X_INS = 64'd3;
`else
  localparam logic [63:0] X_CYC = 64'd0, X_INS = 64'd0;
`endif
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_instr(input logic [3:0] ic, input logic [3:0] fn);
    rst = 1;
    step();
    rst = 0;
    icode = ic;
    ifunc = fn;
    start = 1;
    step();
    start = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    start = 1;
    step();
    step();
    n_chk++;
    if (obs !== ID) $display("FAIL reset_outputs: got %b want %b", obs, ID); else n_pass++;
    n_chk++;
    if ({cyc_cnt, ins_cnt} !== 128'd0) $display("FAIL reset_counters: got %0d/%0d want 0/0", cyc_cnt, ins_cnt); else n_pass++;
    start = 0;
    rst = 0;
    step();
    n_chk++;
    if (obs !== ID) $display("FAIL idle_hold: got %b want %b", obs, ID); else n_pass++;
  endtask
  task automatic test_irmovq();
    logic [12:0] e [6];
    e = '{F, D, E, W, P, F};
    start_instr(4'h3, 4'h0);
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (obs !== e[i]) $display("FAIL irmovq c%0d: got %b want %b", i, obs, e[i]); else n_pass++;
      step();
    end
  endtask
  task automatic test_opq();
    logic [12:0] e [6];
    e = '{F, D, EC, W, P, F};
    start_instr(4'h6, 4'h1);
    dready = 1;
    derr = 1;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (obs !== e[i]) $display("FAIL opq c%0d: got %b want %b", i, obs, e[i]); else n_pass++;
      step();
    end
    dready = 0;
    derr = 0;
  endtask
  task automatic test_pushq_wait();
    logic [12:0] e [9];
    e = '{F, D, E, MW, MW, MW, MW, W, P};
    start_instr(4'hA, 4'h0);
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (obs !== e[i]) $display("FAIL pushq c%0d: got %b want %b", i, obs, e[i]); else n_pass++;
      dready = (i == 6);
      step();
    end
    dready = 0;
    n_chk++;
    if (obs !== F) $display("FAIL pushq_next: got %b want %b", obs, F); else n_pass++;
  endtask
  task automatic test_mem_error();
    logic [12:0] e [4];
    e = '{F, D, E, M};
    start_instr(4'h5, 4'h0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (obs !== e[i]) $display("FAIL mrmovq c%0d: got %b want %b", i, obs, e[i]); else n_pass++;
      if (i == 3) begin
        dready = 1;
        derr = 1;
      end
      step();
    end
    dready = 0;
    derr = 0;
    n_chk++;
    if (obs !== H3) $display("FAIL mem_err_halt: got %b want %b", obs, H3); else n_pass++;
    start = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (obs !== H3) $display("FAIL halt_ignores_start c%0d: got %b want %b", i, obs, H3); else n_pass++;
    end
    start = 0;
  endtask
  task automatic test_decode_faults();
    logic [3:0] ic [8];
    logic [3:0] fn [8];
    logic [12:0] w [8];
    ic = '{4'hC, 4'h6, 4'h0, 4'h2, 4'h7, 4'h7, 4'h6, 4'hB};
    fn = '{4'h0, 4'h5, 4'h0, 4'h7, 4'h7, 4'h6, 4'h3, 4'h0};
    w  = '{H4, H4, H2, H4, H4, E, EC, E};
    for (int k = 0; k < 8; k++) begin
      start_instr(ic[k], fn[k]);
      step();
      n_chk++;
      if (obs[12:4] !== D[12:4]) $display("FAIL decode%0d_d: got %b want %b", k, obs, D); else n_pass++;
      step();
      n_chk++;
      if (obs !== w[k]) $display("FAIL decode%0d: got %b want %b", k, obs, w[k]); else n_pass++;
      if (w[k][12:4] == 9'd0) begin
        step();
        n_chk++;
        if (obs !== w[k]) $display("FAIL decode%0d_hold: got %b want %b", k, obs, w[k]); else n_pass++;
      end
    end
  endtask
  task automatic test_imem_error();
    start_instr(4'h1, 4'h0);
    imem_err = 1;
    step();
    imem_err = 0;
    n_chk++;
    if (obs !== H3) $display("FAIL imem_err: got %b want %b", obs, H3); else n_pass++;
    step();
    n_chk++;
    if (obs !== H3) $display("FAIL imem_err_hold: got %b want %b", obs, H3); else n_pass++;
  endtask
  task automatic test_reset_mid_mem();
    start_instr(4'hA, 4'h0);
    step();
    step();
    step();
    n_chk++;
    if (obs !== MW) $display("FAIL pre_reset_mem: got %b want %b", obs, MW); else n_pass++;
    rst = 1;
    start = 1;
    dready = 1;
    step();
    n_chk++;
    if (obs !== ID) $display("FAIL reset_mid_mem: got %b want %b", obs, ID); else n_pass++;
    n_chk++;
    if ({cyc_cnt, ins_cnt} !== 128'd0) $display("FAIL reset_mid_mem_cnt: got %0d/%0d want 0/0", cyc_cnt, ins_cnt); else n_pass++;
    rst = 0;
    start = 0;
    dready = 0;
    step();
    n_chk++;
    if (obs !== ID) $display("FAIL after_reset_idle: got %b want %b", obs, ID); else n_pass++;
  endtask
  task automatic test_counters();
    start_instr(4'h1, 4'h0);
    for (int i = 0; i < 15; i++) step();
    n_chk++;
    if (ins_cnt !== X_INS) $display("FAIL instr_cnt: got %0d want %0d", ins_cnt, X_INS); else n_pass++;
    n_chk++;
    if (cyc_cnt !== X_CYC) $display("FAIL cycle_cnt: got %0d want %0d", cyc_cnt, X_CYC); else n_pass++;
    n_chk++;
    if (obs !== F) $display("FAIL nop_continue: got %b want %b", obs, F); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_irmovq();
    test_opq();
    test_pushq_wait();
    test_mem_error();
    test_decode_faults();
    test_imem_error();
    test_reset_mid_mem();
    test_counters();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
